// File: rtl/voice_change_pkg.sv
// Shared constants and FSM state type for the voice-change resampler.
package voice_change_pkg;
  localparam int unsigned CH_W   = 16;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned STEP_W = 10;
  localparam int unsigned PEND_W = 3;

  typedef enum logic [1:0] {IDLE, FILL, RUN, SKIP} state_e;
endpackage

// File: rtl/voice_change_lerp.sv
// Two-stage single-channel linear interpolator: y = s0 + ((s1 - s0) * frac) >>> FRAC_W.
// y holds its value unless a started interpolation reaches stage 2.
module voice_change_lerp
  import voice_change_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   s0,
  input  logic [CH_W-1:0]   s1,
  input  logic [FRAC_W-1:0] frac,
  output logic [CH_W-1:0]   y
);
  localparam int unsigned P_W = CH_W + FRAC_W + 2;

  logic signed [CH_W:0]  d;
  logic signed [P_W-1:0] d_x, f_x, s0_x;
  logic signed [P_W-1:0] p_d, p_q;
  logic [CH_W-1:0]       s0_d, s0_q, y_d, y_q;
  logic                  vld_d, vld_q;

  always_comb begin
    d     = {s1[CH_W-1], s1} - {s0[CH_W-1], s0};
    d_x   = P_W'(d);
    f_x   = {{(P_W-FRAC_W){1'b0}}, frac};
    p_d   = start ? d_x * f_x : p_q;
    s0_d  = start ? s0 : s0_q;
    vld_d = start;
    s0_x  = P_W'($signed(s0_q));
    // Only the low CH_W bits survive; the result always lies between s0 and s1.
    y_d   = vld_q ? CH_W'(s0_x + (p_q >>> FRAC_W)) : y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      s0_q  <= '0;
      vld_q <= 1'b0;
      y_q   <= '0;
    end else begin
      p_q   <= p_d;
      s0_q  <= s0_d;
      vld_q <= vld_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;
endmodule

// File: rtl/voice_change_resampler.sv
// Pitch-shifting stereo resampler: two-sample window, Q2.8 phase accumulator,
// per-channel linear interpolation with 2-cycle output latency.
module voice_change_resampler
  import voice_change_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*CH_W-1:0]   in_data,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [STEP_W-1:0]   step,
  input  logic                out_req,
  input  logic                flush,
  output logic [2*CH_W-1:0]   out_data,
  output logic                out_vld,
  output logic                underflow
);
  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2*CH_W-1:0]   s0_q, s0_d, s1_q, s1_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                in_rdy_q, in_rdy_d;
  logic                req1_q, req1_d;
  logic                uf_q, uf_d;
  logic                vld_q, vld_d;
  logic                xfer, start;
  logic [FRAC_W+PEND_W-1:0] acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    frac_d  = frac_q;
    pend_d  = pend_q;
    start   = 1'b0;
    req1_d  = 1'b0;
    uf_d    = 1'b0;
    vld_d   = req1_q;
    xfer    = in_vld & in_rdy_q;
    acc     = (FRAC_W+PEND_W)'(frac_q) + (FRAC_W+PEND_W)'(step);

    if (flush) begin
      state_d = FILL;
      cnt_d   = '0;
      frac_d  = '0;
      pend_d  = '0;
    end else begin
      // A request outside RUN still yields a strobe, repeating the held output.
      if (out_req) begin
        req1_d = 1'b1;
        uf_d   = (state_q != RUN);
      end
      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: if (xfer) begin
          s0_d  = s1_q;
          s1_d  = in_data;
          cnt_d = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
          if (cnt_d == 2'd2) state_d = RUN;
        end
        RUN: if (out_req) begin
          start  = 1'b1;
          frac_d = acc[FRAC_W-1:0];
          pend_d = acc[FRAC_W+PEND_W-1:FRAC_W];
          if (pend_d != '0) state_d = SKIP;
        end
        SKIP: if (xfer) begin
          s0_d   = s1_q;
          s1_d   = in_data;
          pend_d = pend_q - 1'b1;
          if (pend_d == '0) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    in_rdy_d = (state_d == FILL) || ((state_d == SKIP) && (pend_d != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      frac_q   <= '0;
      pend_q   <= '0;
      in_rdy_q <= 1'b0;
      req1_q   <= 1'b0;
      uf_q     <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      frac_q   <= frac_d;
      pend_q   <= pend_d;
      in_rdy_q <= in_rdy_d;
      req1_q   <= req1_d;
      uf_q     <= uf_d;
      vld_q    <= vld_d;
    end
  end

  voice_change_lerp u_lerp_l (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .s0    (s0_q[2*CH_W-1:CH_W]),
    .s1    (s1_q[2*CH_W-1:CH_W]),
    .frac  (frac_q),
    .y     (out_data[2*CH_W-1:CH_W])
  );

  voice_change_lerp u_lerp_r (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .s0    (s0_q[CH_W-1:0]),
    .s1    (s1_q[CH_W-1:0]),
    .frac  (frac_q),
    .y     (out_data[CH_W-1:0])
  );

  assign in_rdy    = in_rdy_q;
  assign out_vld   = vld_q;
  assign underflow = uf_q;
endmodule
